bakery_axi_mem_master: RTL and testbench

- Memory-access stage directly downstream of the Lamport bakery core's control FSM.
- Converts single-word read/write commands (choosing[], number[] and shared-counter accesses) into AXI4-Lite master transactions toward the shared memory at 0xC000_xxxx.
- Returns one response per command: read data plus error flag.
- One instance per bakery core; four cores share the memory through the interconnect.

---
 rtl/bakery_axi_mem_master.sv | 173 +++++++++++++++++
 tb/tb_bakery_axi_mem_master.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bakery_axi_mem_master.sv
// Memory-access stage of a bakery core: single-word commands in, AXI4-Lite master out, one response per command.
// Optional statistics counters are built only when BAKERY_AXI_MEM_STATS_EN is defined.
module bakery_axi_mem_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [2:0]          m_awprot,
  output logic [2:0]          m_arprot,
  output logic [31:0]         stat_rd_cnt,
  output logic [31:0]         stat_wr_cnt,
  output logic [31:0]         stat_err_cnt
);

  localparam int STRB_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

  typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  assign m_awaddr = addr_q;
  assign m_araddr = addr_q;
  assign m_wdata  = wdata_q;
  assign m_wstrb  = '1;
  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  // Command capture: address is word-aligned once here so AW/AR never carry low byte bits.
  always_ff @(posedge clock) begin
    if (state == IDLE && cmd_ready && cmd_valid) begin
      addr_q  <= cmd_addr & ALIGN_MASK;
      wdata_q <= cmd_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      m_awvalid <= 1'b0;
      m_wvalid  <= 1'b0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_rready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_ready && cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_wr) begin
              state     <= WR;
              m_awvalid <= 1'b1;
              m_wvalid  <= 1'b1;
            end else begin
              state     <= RD_AR;
              m_arvalid <= 1'b1;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          if (m_awready) m_awvalid <= 1'b0;
          if (m_wready)  m_wvalid  <= 1'b0;
          // B is only taken once both address and data beats are gone.
          if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
            state    <= WR_B;
            m_bready <= 1'b1;
          end
        end
        WR_B: begin
          if (m_bvalid) begin
            m_bready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_err   <= (m_bresp != 2'b00);
            state     <= RSP;
          end
        end
        RD_AR: begin
          if (m_arready) begin
            m_arvalid <= 1'b0;
            m_rready  <= 1'b1;
            state     <= RD_R;
          end
        end
        RD_R: begin
          if (m_rvalid) begin
            m_rready  <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= m_rdata;
            rsp_err   <= (m_rresp != 2'b00);
            state     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BAKERY_AXI_MEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
  logic [31:0] err_cnt;
  logic        r_hs;
  logic        b_hs;

  assign r_hs = m_rvalid && m_rready;
  assign b_hs = m_bvalid && m_bready;

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      err_cnt <= '0;
    end else begin
      if (r_hs) rd_cnt <= rd_cnt + 32'd1;
      if (b_hs) wr_cnt <= wr_cnt + 32'd1;
      if ((r_hs && m_rresp != 2'b00) || (b_hs && m_bresp != 2'b00))
        err_cnt <= err_cnt + 32'd1;
    end
  end

  assign stat_rd_cnt  = rd_cnt;
  assign stat_wr_cnt  = wr_cnt;
  assign stat_err_cnt = err_cnt;
`else
  assign stat_rd_cnt  = '0;
  assign stat_wr_cnt  = '0;
  assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_bakery_axi_mem_master.sv
// Table-driven bench for bakery_axi_mem_master: a cycle-stepped AXI4-Lite slave model plus a response scoreboard.
module tb_bakery_axi_mem_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_wr = 1'b0;
  logic [ADDR_W-1:0]   cmd_addr = '0;
  logic [DATA_W-1:0]   cmd_data = '0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [DATA_W-1:0]   rsp_data;
  logic                rsp_err;
  logic [ADDR_W-1:0]   m_awaddr;
  logic                m_awvalid;
  logic                m_awready = 1'b0;
  logic [DATA_W-1:0]   m_wdata;
  logic [DATA_W/8-1:0] m_wstrb;
  logic                m_wvalid;
  logic                m_wready = 1'b0;
  logic [1:0]          m_bresp = 2'b00;
  logic                m_bvalid = 1'b0;
  logic                m_bready;
  logic [ADDR_W-1:0]   m_araddr;
  logic                m_arvalid;
  logic                m_arready = 1'b0;
  logic [DATA_W-1:0]   m_rdata = '0;
  logic [1:0]          m_rresp = 2'b00;
  logic                m_rvalid = 1'b0;
  logic                m_rready;
  logic [2:0]          m_awprot;
  logic [2:0]          m_arprot;
  logic [31:0]         stat_rd_cnt;
  logic [31:0]         stat_wr_cnt;
  logic [31:0]         stat_err_cnt;

  bakery_axi_mem_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awprot(m_awprot), .m_arprot(m_arprot),
    .stat_rd_cnt(stat_rd_cnt), .stat_wr_cnt(stat_wr_cnt), .stat_err_cnt(stat_err_cnt)
  );

  always #5 clock = ~clock;

  // Cycle numbering: the accept edge closes cycle 0; e_lat is the cycle in which rsp_valid first shows.
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          aw_dly;
    int          w_dly;
    bit          b_pre;
    int          rsp_hold;
    bit          pre_next;
    bit          chk_wait0;
    logic [31:0] e_data;
    bit          e_err;
    int          e_lat;
    int          e_vhi;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  logic [32:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int rd_m = 0;
  int wr_m = 0;
  int err_m = 0;

  function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endfunction

  function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] rdata, input logic [1:0] resp, input int aw_dly,
                              input int w_dly, input bit b_pre, input int rsp_hold, input bit pre_next,
                              input bit chk_wait0, input logic [31:0] e_data, input bit e_err,
                              input int e_lat, input int e_vhi);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.rdata = rdata; v.resp = resp;
    v.aw_dly = aw_dly; v.w_dly = w_dly; v.b_pre = b_pre; v.rsp_hold = rsp_hold;
    v.pre_next = pre_next; v.chk_wait0 = chk_wait0;
    v.e_data = e_data; v.e_err = e_err; v.e_lat = e_lat; v.e_vhi = e_vhi;
    return v;
  endfunction

  task automatic run_txn(input int idx, input vec_t v, output int lat, output int vhi,
                         output int waited, output int bad_k);
    logic [31:0] ea;
    bit aw_done, w_done, ar_done, b_done, r_done, rsp_done;
    bit aw_hs, w_hs, ar_hs, b_hs, r_hs, rsp_hs, viol;
    int k, hold;
    logic [31:0] hd, hs_data;
    logic he, hs_err;
    logic [32:0] e;
    ea = v.addr & 32'hFFFF_FFFC;
    lat = -1; vhi = 0; waited = 0; bad_k = -1; hold = 0; k = 0;
    aw_done = 0; w_done = 0; ar_done = 0; b_done = 0; r_done = 0; rsp_done = 0;
    aw_hs = 0; w_hs = 0; ar_hs = 0; b_hs = 0; r_hs = 0; rsp_hs = 0;
    hd = '0; he = 1'b0; hs_data = '0; hs_err = 1'b0;
    cmd_valid = 1'b1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_data = v.data;
    m_awready = 0; m_wready = 0; m_arready = 0; m_rvalid = 0; rsp_ready = 0;
    m_bvalid = v.b_pre; m_bresp = v.resp; m_rresp = v.resp; m_rdata = v.rdata;
    while (!cmd_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!cmd_ready) begin
      check($sformatf("v%0d_accept_timeout", idx), 1'b0, 1'b1);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back({v.e_err, v.e_data});
    @(negedge clock);
    cmd_valid = 1'b0;
    k = 1;
    while (k < 200) begin
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done  = 1;
      if (ar_hs) ar_done = 1;
      if (b_hs)  b_done  = 1;
      if (r_hs)  r_done  = 1;
      if (rsp_hs) begin
        rsp_done = 1;
        if (exp_q.size() == 0) check($sformatf("v%0d_unexpected_rsp", idx), 1'b1, 1'b0);
        else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_rsp_data", idx), hs_data, e[31:0]);
          check($sformatf("v%0d_rsp_err", idx), hs_err, e[32]);
        end
        break;
      end
      // Expected handshake-state view of every DUT output this cycle.
      viol = 1'b0;
      viol |= (m_awvalid !== (v.wr && !aw_done));
      viol |= (m_wvalid  !== (v.wr && !w_done));
      viol |= (m_bready  !== (v.wr && aw_done && w_done && !b_done));
      viol |= (m_arvalid !== (!v.wr && !ar_done));
      viol |= (m_rready  !== (!v.wr && ar_done && !r_done));
      viol |= (rsp_valid !== (b_done || r_done));
      viol |= (cmd_ready !== 1'b0);
      viol |= (m_awvalid && m_awaddr !== ea);
      viol |= (m_wvalid && (m_wdata !== v.data || m_wstrb !== 4'hF));
      viol |= (m_arvalid && m_araddr !== ea);
      viol |= (m_awprot !== 3'b000 || m_arprot !== 3'b000);
      if (m_awvalid || m_arvalid) vhi++;
      if (rsp_valid) begin
        if (lat < 0) begin
          lat = k; hd = rsp_data; he = rsp_err;
        end else viol |= (rsp_data !== hd || rsp_err !== he);
      end
      if (viol && bad_k < 0) bad_k = k;
      m_awready = (k > v.aw_dly);
      m_wready  = (k > v.w_dly);
      m_arready = (k > v.aw_dly);
      m_bvalid  = !b_done && (v.b_pre || (aw_done && w_done));
      m_rvalid  = !r_done && ar_done;
      rsp_ready = rsp_valid && (hold >= v.rsp_hold);
      if (rsp_valid) hold++;
      if (v.pre_next && rsp_valid) cmd_valid = 1'b1;
      aw_hs = m_awvalid && m_awready;
      w_hs  = m_wvalid && m_wready;
      ar_hs = m_arvalid && m_arready;
      b_hs  = m_bvalid && m_bready;
      r_hs  = m_rvalid && m_rready;
      rsp_hs = rsp_valid && rsp_ready;
      hs_data = rsp_data; hs_err = rsp_err;
      @(negedge clock);
      k++;
    end
    if (!rsp_done) begin
      check($sformatf("v%0d_rsp_timeout", idx), 1'b0, 1'b1);
      exp_q.delete();
    end
    if (rsp_valid !== 1'b0 && bad_k < 0) bad_k = k;
    m_awready = 0; m_wready = 0; m_arready = 0; m_bvalid = 0; m_rvalid = 0; rsp_ready = 0;
  endtask

  task automatic apply_vec(input int i);
    int lat, vhi, waited, bad_k;
    logic [31:0] e_rd, e_wr, e_err;
    run_txn(i, vecs[i], lat, vhi, waited, bad_k);
    if (vecs[i].wr) wr_m++; else rd_m++;
    if (vecs[i].resp != 2'b00) err_m++;
    check($sformatf("v%0d_latency", i), lat, vecs[i].e_lat);
    check($sformatf("v%0d_addr_valid_cycles", i), vhi, vecs[i].e_vhi);
    check($sformatf("v%0d_protocol_first_bad_cycle", i), bad_k, -1);
    if (vecs[i].chk_wait0) check($sformatf("v%0d_accept_wait", i), waited, 0);
`ifdef BAKERY_AXI_MEM_STATS_EN
    e_rd = rd_m; e_wr = wr_m; e_err = err_m;
`else
    e_rd = 0; e_wr = 0; e_err = 0;
`endif
    check($sformatf("v%0d_stat_rd", i), stat_rd_cnt, e_rd);
    check($sformatf("v%0d_stat_wr", i), stat_wr_cnt, e_wr);
    check($sformatf("v%0d_stat_err", i), stat_err_cnt, e_err);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    //            wr addr          data          rdata         rsp  aw w  bp hold pn cw0 e_data        err lat vhi
    vecs[0] = mk(1, 32'hC000_1008, 32'h0000_0000, 32'h0,        2'd0, 0, 0, 0, 0,  0, 0, 32'h0,        0,  3,  1);
    vecs[1] = mk(0, 32'hC000_1008, 32'h0,        32'h0000_0013, 2'd0, 0, 0, 0, 0,  0, 0, 32'h0000_0013, 0,  3,  1);
    vecs[2] = mk(1, 32'hC000_0010, 32'h0000_1234, 32'h0,        2'd0, 5, 0, 1, 0,  0, 0, 32'h0,        0,  8,  6);
    vecs[3] = mk(0, 32'hC000_0004, 32'h0,        32'h0000_DEAD, 2'd2, 0, 0, 0, 0,  0, 0, 32'h0000_DEAD, 1,  3,  1);
    vecs[4] = mk(1, 32'hC000_0020, 32'hCAFE_0004, 32'h0,        2'd3, 0, 3, 0, 0,  0, 0, 32'h0,        1,  6,  1);
    vecs[5] = mk(0, 32'hC000_100B, 32'h0,        32'hA5A5_0001, 2'd0, 2, 0, 0, 0,  0, 0, 32'hA5A5_0001, 0,  5,  3);
    vecs[6] = mk(1, 32'hC000_2000, 32'hFFFF_FFFF, 32'h0,        2'd0, 2, 2, 0, 10, 1, 0, 32'h0,        0,  5,  3);
    vecs[7] = mk(0, 32'hC000_1000, 32'h0,        32'h0000_0002, 2'd0, 0, 0, 0, 0,  0, 1, 32'h0000_0002, 0,  3,  1);
    vecs[8] = mk(1, 32'hC000_3002, 32'h0000_0055, 32'h0,        2'd0, 0, 0, 0, 0,  0, 0, 32'h0,        0,  3,  1);

    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("reset_ctrl", {cmd_ready, m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err}, 8'h00);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_stats", {stat_rd_cnt, stat_wr_cnt} | 64'(stat_err_cnt), 64'h0);
    reset = 1'b0;
    @(negedge clock);
    check("cmd_ready_after_reset", cmd_ready, 1'b1);

    for (int i = 0; i < NV - 1; i++) apply_vec(i);

    // Reset while a write is stuck in WR with AW and W both pending.
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 32'hC000_0040; cmd_data = 32'h1111_2222;
    m_awready = 0; m_wready = 0; m_bvalid = 0;
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clock);
      w++;
    end
    check("rst_mid_accept", cmd_ready, 1'b1);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("rst_mid_awvalid_before", {m_awvalid, m_wvalid}, 2'b11);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_mid_outputs", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, rsp_valid, cmd_ready}, 7'h00);
    check("rst_mid_stats", {stat_rd_cnt, stat_wr_cnt} | 64'(stat_err_cnt), 64'h0);
    reset = 1'b0;
    rd_m = 0; wr_m = 0; err_m = 0;
    @(negedge clock);
    check("rst_mid_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    apply_vec(NV - 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
